// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR burst arbiter.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_DDR_DATA_WIDTH = 128;
    localparam int DEF_DDR_ADDR_WIDTH = 28;
    localparam int DEF_CH_DATA_WIDTH  = 16;
    localparam int DEF_LEN_WIDTH      = 10;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: first requester at or after the pointer wins.
module rr_arbiter import ddr_arb_pkg::*; #(
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int PW     = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     pointer,
    output logic [NUM_CH-1:0] grant
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = PW'((int'(pointer) + i) % NUM_CH);
            if (grant == '0 && req[idx]) grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Multi-channel DDR burst arbiter: round-robin grant, one burst at a time.
// Define DDR_ARB_TIMEOUT_EN to add a per-burst watchdog that aborts with ch_err.
module ddr_burst_arbiter import ddr_arb_pkg::*; #(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH,
    parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
    parameter int CH_DATA_WIDTH  = DEF_CH_DATA_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               mem_clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  ch_req,
    input  logic [NUM_CH-1:0]                  ch_we,
    input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_len,
    input  logic [NUM_CH*CH_DATA_WIDTH-1:0]    ch_wdata,
    output logic [NUM_CH-1:0]                  ch_grant,
    output logic [NUM_CH-1:0]                  ch_wdata_req,
    output logic [CH_DATA_WIDTH-1:0]           ch_rdata,
    output logic [NUM_CH-1:0]                  ch_rdata_valid,
    output logic [NUM_CH-1:0]                  ch_done,
    output logic [NUM_CH-1:0]                  ch_err,
    output logic                               rd_burst_req,
    output logic                               wr_burst_req,
    output logic [LEN_WIDTH-1:0]               rd_burst_len,
    output logic [LEN_WIDTH-1:0]               wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
    input  logic                               rd_burst_data_valid,
    input  logic                               wr_burst_data_req,
    input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
    input  logic                               rd_burst_finish,
    input  logic                               wr_burst_finish,
    output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data
);

    localparam int PW = idx_w(NUM_CH);

    arb_state_e                state_q, state_d;
    logic [NUM_CH-1:0]         grant_q, sel_oh;
    logic [PW-1:0]             ptr_q, sel_idx, g_idx;
    logic [LEN_WIDTH-1:0]      len_q, beat_q, beats_now;
    logic                      err_q;
    logic                      rd_req_q, wr_req_q;
    logic [LEN_WIDTH-1:0]      rd_len_q, wr_len_q;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [CH_DATA_WIDTH-1:0]  rdata_q;
    logic [NUM_CH-1:0]         rvalid_q;
    logic [DDR_DATA_WIDTH-1:0] wdata_q;

    logic [DDR_ADDR_WIDTH-1:0] win_addr;
    logic [LEN_WIDTH-1:0]      win_len;
    logic                      win_we, win_nz;
    logic [CH_DATA_WIDTH-1:0]  g_wdata;
    logic                      beat_inc, finish_ok, timeout, burst_end;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req     (ch_req),
        .pointer (ptr_q),
        .grant   (sel_oh)
    );

    always_comb begin
        sel_idx = '0;
        g_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_oh[i])  sel_idx = PW'(i);
            if (grant_q[i]) g_idx   = PW'(i);
        end
    end

    assign win_addr = ch_addr[sel_idx*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
    assign win_len  = ch_len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
    assign win_we   = ch_we[sel_idx];
    assign win_nz   = (win_len != '0);
    assign g_wdata  = ch_wdata[g_idx*CH_DATA_WIDTH +: CH_DATA_WIDTH];

    // A beat arriving on the finish cycle still counts toward the length check.
    assign beat_inc  = (state_q == ST_RD_BURST && rd_burst_data_valid) ||
                       (state_q == ST_WR_BURST && wr_burst_data_req);
    assign beats_now = beat_q + LEN_WIDTH'(beat_inc);
    assign finish_ok = (state_q == ST_RD_BURST && rd_burst_finish) ||
                       (state_q == ST_WR_BURST && wr_burst_finish);
    assign burst_end = finish_ok || timeout;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q;

    always_ff @(posedge mem_clk) begin
        if (rst || state_q == ST_IDLE || state_q == ST_DONE) wd_q <= '0;
        else                                                 wd_q <= wd_q + 1'b1;
    end

    assign timeout = (state_q == ST_RD_BURST || state_q == ST_WR_BURST) &&
                     (wd_q == WDW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge mem_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (|ch_req) state_d = !win_nz ? ST_DONE :
                                               (win_we ? ST_WR_BURST : ST_RD_BURST);
            ST_RD_BURST: if (burst_end) state_d = ST_DONE;
            ST_WR_BURST: if (burst_end) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ch_grant     = '0;
        ch_wdata_req = '0;
        ch_done      = '0;
        ch_err       = '0;
        case (state_q)
            ST_RD_BURST: ch_grant = grant_q;
            ST_WR_BURST: begin
                ch_grant = grant_q;
                if (wr_burst_data_req) ch_wdata_req = grant_q;
            end
            ST_DONE: begin
                ch_done = grant_q;
                if (err_q) ch_err = grant_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            grant_q   <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_len_q  <= '0;
            wr_len_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= '0;
            wdata_q   <= '0;
        end else begin
            rvalid_q <= '0;
            if (beat_inc) beat_q <= beats_now;
            if (state_q == ST_RD_BURST && rd_burst_data_valid) begin
                rdata_q  <= rd_burst_data[CH_DATA_WIDTH-1:0];
                rvalid_q <= grant_q;
            end
            if (state_q == ST_WR_BURST && wr_burst_data_req)
                wdata_q <= DDR_DATA_WIDTH'(g_wdata);
            case (state_q)
                ST_IDLE: if (|ch_req) begin
                    grant_q   <= sel_oh;
                    len_q     <= win_len;
                    beat_q    <= '0;
                    err_q     <= 1'b0;
                    rd_req_q  <= win_nz && !win_we;
                    rd_addr_q <= (win_nz && !win_we) ? win_addr : '0;
                    rd_len_q  <= (win_nz && !win_we) ? win_len  : '0;
                    wr_req_q  <= win_nz && win_we;
                    wr_addr_q <= (win_nz && win_we) ? win_addr : '0;
                    wr_len_q  <= (win_nz && win_we) ? win_len  : '0;
                end
                ST_RD_BURST, ST_WR_BURST: if (burst_end) begin
                    rd_req_q <= 1'b0;
                    wr_req_q <= 1'b0;
                    err_q    <= !finish_ok || (beats_now != len_q);
                end
                ST_DONE: begin
                    grant_q <= '0;
                    ptr_q   <= (g_idx == PW'(NUM_CH - 1)) ? '0 : g_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        if (DDR_DATA_WIDTH > CH_DATA_WIDTH) begin : g_unused
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^rd_burst_data[DDR_DATA_WIDTH-1:CH_DATA_WIDTH];
        end
    endgenerate

    assign rd_burst_req   = rd_req_q;
    assign wr_burst_req   = wr_req_q;
    assign rd_burst_len   = rd_len_q;
    assign wr_burst_len   = wr_len_q;
    assign rd_burst_addr  = rd_addr_q;
    assign wr_burst_addr  = wr_addr_q;
    assign ch_rdata       = rdata_q;
    assign ch_rdata_valid = rvalid_q;
    assign wr_burst_data  = wdata_q;

endmodule
